ncl_wavefront_driver: RTL and testbench

- Synchronous front end that feeds a dual-rail NULL-convention NAND stage (inputs x0/x1/y0/y1, outputs o0/o1).
- Accepts a binary operand pair, drives a DATA wavefront and then a NULL wavefront on the dual-rail inputs, and waits for completion on the stage outputs.
- Returns the captured result, a mismatch flag against the expected NAND value, and error flags.
- Sits between board-level test control (pins or a pattern generator) and the self-timed gate.

---
 rtl/ncl_wavefront_driver.sv | 163 ++++++++++++++++
 tb/tb_ncl_wavefront_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_wavefront_driver.sv
// Drives one DATA then one NULL wavefront into a dual-rail NCL NAND stage and reports the captured result.
// Latency about 2*(1+SYNC_STAGES+SETTLE_CYCLES)+1 cycles to res_valid; start_ready low while busy; result held until res_ready.
module ncl_wavefront_driver #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       a,
    input  logic       b,
    output logic       x0,
    output logic       x1,
    output logic       y0,
    output logic       y1,
    input  logic       o0,
    input  logic       o1,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_data,
    output logic       res_mismatch,
    output logic [1:0] res_err,
    output logic       busy
);

    localparam int            SW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    // Compared against the count before this cycle's increment, so a wait
    // phase lasts exactly TIMEOUT_CYCLES cycles when nothing completes.
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE_DATA,
        S_WAIT_DATA,
        S_DRIVE_NULL,
        S_WAIT_NULL,
        S_REPORT
    } state_t;

    state_t        state;
    logic [1:0]    sync_q [SYNC_STAGES];
    logic [1:0]    smp;
    logic [1:0]    smp_nxt;
    logic [SW-1:0] stab_cnt;
    logic          settled;
    logic [TW-1:0] tcnt;
    logic          to_hit;
    logic          op_a;
    logic          op_b;

    assign smp     = sync_q[SYNC_STAGES-1];
    assign smp_nxt = sync_q[SYNC_STAGES-2];
    assign settled = (stab_cnt == SETTLE_MAX);
    assign to_hit  = (tcnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
        end else begin
            sync_q[0] <= {o1, o0};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // stab_cnt = number of consecutive cycles smp has shown its current value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else if (smp_nxt != smp) begin
            stab_cnt <= SW'(1);
        end else if (stab_cnt != SETTLE_MAX) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (state == S_WAIT_DATA || state == S_WAIT_NULL) begin
            if (tcnt != '1) tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    assign start_ready = (state == S_IDLE) && settled && (smp == 2'b00);
    assign res_valid   = (state == S_REPORT);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            x0           <= 1'b0;
            x1           <= 1'b0;
            y0           <= 1'b0;
            y1           <= 1'b0;
            op_a         <= 1'b0;
            op_b         <= 1'b0;
            res_data     <= 1'b0;
            res_mismatch <= 1'b0;
            res_err      <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid && start_ready) begin
                        op_a         <= a;
                        op_b         <= b;
                        res_data     <= 1'b0;
                        res_mismatch <= 1'b0;
                        res_err      <= 2'b00;
                        state        <= S_DRIVE_DATA;
                    end
                end
                S_DRIVE_DATA: begin
                    x1    <= op_a;
                    x0    <= ~op_a;
                    y1    <= op_b;
                    y0    <= ~op_b;
                    state <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    // An illegal code aborts at once; it is never filtered by settling.
                    if (smp == 2'b11) begin
                        res_err[1] <= 1'b1;
                        state      <= S_DRIVE_NULL;
                    end else if (settled && (smp[1] ^ smp[0])) begin
                        res_data     <= smp[1];
                        res_mismatch <= smp[1] ^ ~(op_a & op_b);
                        state        <= S_DRIVE_NULL;
                    end else if (to_hit) begin
                        res_err[0] <= 1'b1;
                        state      <= S_DRIVE_NULL;
                    end
                end
                S_DRIVE_NULL: begin
                    x0    <= 1'b0;
                    x1    <= 1'b0;
                    y0    <= 1'b0;
                    y1    <= 1'b0;
                    state <= S_WAIT_NULL;
                end
                S_WAIT_NULL: begin
                    if (smp == 2'b11) res_err[1] <= 1'b1;
                    if (settled && smp == 2'b00) begin
                        state <= S_REPORT;
                    end else if (to_hit) begin
                        res_err[0] <= 1'b1;
                        state      <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ncl_wavefront_driver.sv
// Bench for ncl_wavefront_driver: a behavioural NCL NAND stage with a 2-cycle delay and fault modes, plus a result scoreboard.
`timescale 1ns/1ps
module tb_ncl_wavefront_driver;

    localparam int TO = 15;
    localparam int M_IDEAL  = 0;
    localparam int M_STUCK  = 1;
    localparam int M_GLITCH = 2;
    localparam int M_WRONG  = 3;

    typedef struct packed {
        logic       d;
        logic       m;
        logic [1:0] e;
    } res_t;

    typedef struct {
        logic a;
        logic b;
        int   mode;
        res_t e;
        int   rails;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid, start_ready, a, b;
    logic       x0, x1, y0, y1, o0, o1;
    logic       res_valid, res_ready, res_data, res_mismatch, busy;
    logic [1:0] res_err;

    int   total = 0;
    int   bad = 0;
    int   mode = M_IDEAL;
    res_t exp_q[$];

    always #5 clk = ~clk;

    ncl_wavefront_driver #(
        .SYNC_STAGES(2), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(TO), .TW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .o0(o0), .o1(o1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_mismatch(res_mismatch), .res_err(res_err),
        .busy(busy)
    );

    // Gate model: DATA out only when both inputs DATA, NULL only when both NULL.
    logic [1:0] raw, eff;
    logic [1:0] raw_q = 2'b00, p1 = 2'b00, p2 = 2'b00;
    logic       nv;
    assign nv = (mode == M_WRONG) ? (x1 & y1) : ~(x1 & y1);

    always_comb begin
        raw = raw_q;
        if ((x0 ^ x1) && (y0 ^ y1)) raw = {nv, ~nv};
        else if (!x0 && !x1 && !y0 && !y1) raw = 2'b00;
        if (mode == M_STUCK) raw = 2'b00;
        eff = (mode == M_GLITCH && raw_q == 2'b00 && raw != 2'b00) ? 2'b11 : raw;
    end

    always @(posedge clk) begin
        raw_q <= raw;
        p1    <= eff;
        p2    <= p1;
    end
    assign o1 = p2[1];
    assign o0 = p2[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result got d=%0b m=%0b e=%02b required none", res_data, res_mismatch, res_err);
            end else begin
                res_t exp_r;
                exp_r = exp_q.pop_front();
                chk("result{d,m,err}", {res_data, res_mismatch, res_err}, exp_r);
            end
        end
    end

    // Rails: never 11, never a direct DATA-to-DATA change.
    logic [3:0] prev_r = 4'b0;
    always @(negedge clk) begin
        if (rst_n && {x1, x0, y1, y0} != 4'b0) begin
            chk("rail_legal",
                ((x0 & x1) | (y0 & y1) |
                 ((prev_r[3] ^ prev_r[2]) & (x1 ^ x0) & (prev_r[3] != x1)) |
                 ((prev_r[1] ^ prev_r[0]) & (y1 ^ y0) & (prev_r[1] != y1))), 0);
        end
        prev_r <= {x1, x0, y1, y0};
    end

    task automatic issue(input logic ta, input logic tbv, input res_t e, input bit push);
        int n = 0;
        while (!start_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_ready_wait", start_ready, 1);
        start_valid = 1'b1;
        a = ta;
        b = tbv;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = ~ta;
        b = ~tbv;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(output int rc);
        int n = 0;
        rc = 0;
        while (n < 400) begin
            @(negedge clk);
            if (!busy) break;
            if ({x1, x0, y1, y0} != 4'b0) rc++;
            n++;
        end
        @(posedge clk); #1;
        chk("txn_done", busy, 0);
    endtask

    vec_t vecs [7];

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int nv_cnt;
        int n;
        start_valid = 1'b0;
        a = 1'b0;
        b = 1'b0;
        res_ready = 1'b1;

        // Rail-count expectations: ideal = 2 gate + 2 sync + 2 settle + 1 DRIVE_NULL;
        // stuck = TO wait cycles + 1; glitch aborts one cycle after the 11 is synchronized.
        vecs[0] = '{1'b0, 1'b0, M_IDEAL,  4'b1000, 7};
        vecs[1] = '{1'b0, 1'b1, M_IDEAL,  4'b1000, 7};
        vecs[2] = '{1'b1, 1'b0, M_IDEAL,  4'b1000, 7};
        vecs[3] = '{1'b1, 1'b1, M_IDEAL,  4'b0000, 7};
        vecs[4] = '{1'b1, 1'b1, M_WRONG,  4'b1100, 7};
        vecs[5] = '{1'b1, 1'b0, M_STUCK,  4'b0001, TO + 1};
        vecs[6] = '{1'b0, 1'b1, M_GLITCH, 4'b0010, 6};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rails", {x1, x0, y1, y0}, 0);
        chk("rst_start_ready", start_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_mismatch", res_mismatch, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode;
            issue(vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
            wait_done(rc);
            chk($sformatf("rail_cycles_v%0d", i), rc, vecs[i].rails);
        end

        // Backpressure: result must hold while res_ready is low.
        mode = M_IDEAL;
        res_ready = 1'b0;
        issue(1'b1, 1'b1, 4'b0000, 1'b1);
        n = 0;
        while (!res_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_wait", res_valid, 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_data", {res_data, res_mismatch, res_err}, 4'b0000);
            chk("bp_start_ready", start_ready, 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_valid", res_valid, 0);

        // Reset during WAIT_DATA: rails drop asynchronously, no result appears.
        mode = M_STUCK;
        issue(1'b1, 1'b1, 4'b0000, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_rails", {x1, x0, y1, y0}, 4'b1010);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rails", {x1, x0, y1, y0}, 0);
        chk("async_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nv_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) nv_cnt++;
        end
        chk("post_rst_no_valid", nv_cnt, 0);
        chk("post_rst_ready", start_ready, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
